dmem_arbiter: RTL and testbench

//  Two-port arbiter sharing the single-port data memory (2048 x 32, registered

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 21 ++
 rtl/dmem_arbiter_rr_arb2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 69 ++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared widths, port identifiers and the muxed memory request type
package dmem_arb_pkg;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MAX_LOCK_DEF = 8;

    typedef enum logic {PORT0, PORT1} port_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_req_if: one requester port of the data-memory arbiter
interface dmem_req_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);

    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, lock, addr, wd, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wd, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with bounded lock extension for the owner
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    port_e          last_q, last_d, win;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           both, hold;

    // Pick the winner; the owner keeps a contended bus only while locked and under budget
    always_comb begin
        both   = &req_i;
        hold   = lock_i[last_q] && (cnt_q < CW'(MAX_LOCK));
        win    = both ? (hold ? last_q : port_e'(~last_q)) : (req_i[1] ? PORT1 : PORT0);
        gnt_o  = (en_i && |req_i) ? (win == PORT1 ? 2'b10 : 2'b01) : 2'b00;
        last_d = |gnt_o ? win : last_q;
        cnt_d  = !(|gnt_o) ? cnt_q :
                 (both && win == last_q) ? (cnt_q == CW'(MAX_LOCK) ? cnt_q : cnt_q + 1'b1) : '0;
    end

    // Last owner and consecutive contended-grant count; P1 as owner lets P0 win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT1;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU port and a secondary master
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_req_if.slave         p0,
    dmem_req_if.slave         p1,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i
);

    logic [1:0]        gnt;
    logic              run_q;
    logic              rd_pend_q, rd_pend_d;
    port_e             rd_tag_q, rd_tag_d;
    logic [ADDR_W-1:0] mem_a_q;
    logic [DATA_W-1:0] mem_wd_q;
    mem_req_t          cur;

    rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (run_q),
        .req_i  ({p1.req, p0.req}),
        .lock_i ({p1.lock, p0.lock}),
        .gnt_o  (gnt)
    );

    assign p0.gnt    = gnt[0];
    assign p1.gnt    = gnt[1];
    assign p0.rvalid = rd_pend_q && rd_tag_q == PORT0;
    assign p1.rvalid = rd_pend_q && rd_tag_q == PORT1;
    assign p0.rdata  = p0.rvalid ? mem_rd_i : '0;
    assign p1.rdata  = p1.rvalid ? mem_rd_i : '0;

    // Route the granted request to memory; address/data hold their last value when idle
    always_comb begin
        cur       = gnt[1] ? '{we: p1.we, addr: p1.addr, wd: p1.wd}
                           : '{we: p0.we, addr: p0.addr, wd: p0.wd};
        mem_we_o  = |gnt & cur.we;
        mem_a_o   = |gnt ? cur.addr : mem_a_q;
        mem_wd_o  = |gnt ? cur.wd : mem_wd_q;
        rd_pend_d = |gnt & ~cur.we;
        rd_tag_d  = gnt[1] ? PORT1 : PORT0;
    end

    // Run flag, read-return tag and held bus; reset drops any read still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= PORT0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
        end else begin
            run_q     <= 1'b1;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
            mem_a_q   <= mem_a_o;
            mem_wd_q  <= mem_wd_o;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queue scoreboard on the read-return path
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] mem [2048];

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    dmem_req_if p0_if ();
    dmem_req_if p1_if ();

    dmem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0       (p0_if),
        .p1       (p1_if),
        .mem_we_o (mem_we),
        .mem_a_o  (mem_a),
        .mem_wd_o (mem_wd),
        .mem_rd_i (mem_rd)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial for (int i = 0; i < 2048; i++) mem[i] = 32'hA500_0000 | i;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[12:2]] <= mem_wd;
        mem_rd <= mem[mem_a[12:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic idle();
        p0_if.req = 0; p0_if.we = 0; p0_if.lock = 0;
        p1_if.req = 0; p1_if.we = 0; p1_if.lock = 0;
    endtask

    function automatic logic [31:0] gnts();
        return {30'd0, p1_if.gnt, p0_if.gnt};
    endfunction

    function automatic logic [31:0] rvs();
        return {30'd0, p1_if.rvalid, p0_if.rvalid};
    endfunction

    // Monitor: every presented read return must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (p0_if.rvalid || p1_if.rvalid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got rvalid %b%b expected none", p1_if.rvalid, p0_if.rvalid);
            end else begin
                e = q.pop_front();
                chk("sb_port", rvs(), e.port ? 32'd2 : 32'd1);
                chk("sb_data", e.port ? p1_if.rdata : p0_if.rdata, e.data);
            end
        end else begin
            chk("idle_rdata", p0_if.rdata | p1_if.rdata, 32'd0);
        end
    end

    initial begin
        p0_if.addr = 0; p0_if.wd = 0; p1_if.addr = 0; p1_if.wd = 0;
        idle();
        rst_n = 0;
        p0_if.req = 1; p1_if.req = 1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnts(), 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_rvalid", rvs(), 0);
        @(posedge clk); #1;
        rst_n = 1;
        p0_if.addr = 32'h10; p1_if.addr = 32'h20;
        @(negedge clk);
        chk("run0_gnt", gnts(), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_gnt", gnts(), (k % 2) ? 32'd2 : 32'd1);
            push(k % 2, (k % 2) ? 32'hA500_0008 : 32'hA500_0004);
        end
        @(posedge clk); #1;
        idle();
        p0_if.req = 1; p0_if.addr = 32'h10;
        @(negedge clk);
        chk("t1_gnt", gnts(), 1);
        chk("t1_mem_a", mem_a, 32'h10);
        chk("t1_mem_we", mem_we, 0);
        push(0, 32'hA500_0004);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("t1_rvalid", rvs(), 1);
        chk("t1_hold_a", mem_a, 32'h10);
        chk("t1_idle_we", mem_we, 0);
        @(posedge clk); #1;
        p1_if.req = 1; p1_if.we = 1; p1_if.addr = 32'h40; p1_if.wd = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t4_wr_gnt", gnts(), 2);
        chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_a", mem_a, 32'h40);
        chk("t4_mem_wd", mem_wd, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        idle();
        p0_if.req = 1; p0_if.addr = 32'h40;
        @(negedge clk);
        chk("t4_rd_gnt", gnts(), 1);
        chk("t4_wr_norv", rvs(), 0);
        push(0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        p0_if.addr = 32'h0;
        @(negedge clk);
        chk("t5_gnt_a", gnts(), 1);
        push(0, 32'hA500_0000);
        @(posedge clk); #1;
        idle();
        p1_if.req = 1; p1_if.addr = 32'h4;
        @(negedge clk);
        chk("t5_gnt_b", gnts(), 2);
        chk("t5_rv_a", rvs(), 1);
        push(1, 32'hA500_0001);
        @(posedge clk); #1;
        idle();
        p0_if.req = 1; p0_if.addr = 32'h8;
        @(negedge clk);
        chk("t5_gnt_c", gnts(), 1);
        chk("t5_rv_b", rvs(), 2);
        push(0, 32'hA500_0002);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("t5_rv_c", rvs(), 1);
        @(posedge clk); #1;
        p0_if.req = 1; p0_if.addr = 32'h10;
        @(negedge clk);
        chk("t6_gnt", gnts(), 1);
        @(posedge clk); #1;
        rst_n = 0;
        idle();
        p0_if.req = 1; p1_if.req = 1; p1_if.addr = 32'h20;
        @(negedge clk);
        chk("t6_rst_rvalid", rvs(), 0);
        chk("t6_rst_gnt", gnts(), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("t6_run0_gnt", gnts(), 0);
        @(negedge clk);
        chk("t6_first_gnt", gnts(), 1);
        push(0, 32'hA500_0004);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 0;
        p0_if.req = 1; p1_if.req = 1; p1_if.lock = 1;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("t3_run0_gnt", gnts(), 0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("t3_lock_gnt", gnts(), (k < 8) ? 32'd2 : 32'd1);
            push(k < 8, (k < 8) ? 32'hA500_0008 : 32'hA500_0004);
        end
        @(posedge clk); #1;
        idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
